// File: rtl/sum_stationary_pkg.sv
// Shared types and sizing helpers for the output-stationary MAC array.
package sum_stationary_pkg;

  typedef enum logic [1:0] {
    FEED  = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic int acc_width(input int dw, input int max_k);
    return 2 * dw + $clog2(max_k);
  endfunction

endpackage

// File: rtl/ss_mac_pe.sv
// One processing element: mode-aware multiply-accumulate with west->east / north->south forwarding.
module ss_mac_pe
  import sum_stationary_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 20
) (
  input  logic                  clk,
  input  logic                  reset_ni,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic                  signed_i,
  input  logic [DATA_WIDTH-1:0] west_i,
  input  logic [DATA_WIDTH-1:0] north_i,
  output logic [DATA_WIDTH-1:0] east_o,
  output logic [DATA_WIDTH-1:0] south_o,
  output logic [ACC_WIDTH-1:0]  acc_o
);

  logic signed [DATA_WIDTH:0]     w_ext;
  logic signed [DATA_WIDTH:0]     n_ext;
  logic signed [2*DATA_WIDTH+1:0] prod;
  logic [ACC_WIDTH-1:0]           acc_q, acc_d;
  logic [DATA_WIDTH-1:0]          east_q, south_q;

  // One extra bit lets a single signed multiplier serve both operand modes.
  assign w_ext = {signed_i & west_i[DATA_WIDTH-1], west_i};
  assign n_ext = {signed_i & north_i[DATA_WIDTH-1], north_i};
  assign prod  = w_ext * n_ext;
  assign acc_d = acc_q + ACC_WIDTH'(prod);

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      acc_q   <= '0;
      east_q  <= '0;
      south_q <= '0;
    end else if (clr_i) begin
      acc_q   <= '0;
      east_q  <= '0;
      south_q <= '0;
    end else if (en_i) begin
      acc_q   <= acc_d;
      east_q  <= west_i;
      south_q <= north_i;
    end
  end

  assign east_o  = east_q;
  assign south_o = south_q;
  assign acc_o   = acc_q;

endmodule

// File: rtl/sum_stationary_stream.sv
// Output-stationary ROWSxCOLS systolic MAC array with skewed operand feed and row-wise drain.
// state | meaning: FEED accept beats | FLUSH push zeros through skew | DRAIN emit rows 0..ROWS-1
module sum_stationary_stream
  import sum_stationary_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int MAX_K      = 16,
  parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, MAX_K),
  localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                            clk,
  input  logic                            reset_ni,
  input  logic                            signed_i,
  input  logic                            in_valid_i,
  output logic                            in_ready_o,
  input  logic                            in_last_i,
  input  logic [ROWS-1:0][DATA_WIDTH-1:0] a_i,
  input  logic [COLS-1:0][DATA_WIDTH-1:0] b_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [RW-1:0]                   out_row_o,
  output logic [COLS-1:0][ACC_WIDTH-1:0]  c_o,
  output logic                            kover_o
);

  localparam int FW = $clog2(ROWS + COLS);
  localparam int KW = $clog2(MAX_K + 1);
  localparam logic [FW-1:0] FLUSH_INIT = FW'((ROWS + COLS > 2) ? ROWS + COLS - 3 : 0);

  state_e                         state_q;
  logic                           in_ready_q, out_valid_q, kover_q, mode_q;
  logic [RW-1:0]                  row_q, row_nxt;
  logic [KW-1:0]                  kcnt_q;
  logic [FW-1:0]                  fcnt_q;
  logic [COLS-1:0][ACC_WIDTH-1:0] c_q;

  logic accept, flushing, en, clr, mode_eff, unused_edge;
  logic [DATA_WIDTH-1:0] h_w   [ROWS][COLS+1];
  logic [DATA_WIDTH-1:0] v_w   [ROWS+1][COLS];
  logic [ACC_WIDTH-1:0]  acc_w [ROWS][COLS];

  assign accept   = in_valid_i & in_ready_q;
  assign flushing = (state_q == FLUSH);
  assign en       = accept | flushing;
  assign clr      = (state_q == DRAIN) & out_valid_q & out_ready_i & (row_q == RW'(ROWS - 1));
  // The first beat's MAC happens on the same edge that latches the tile mode.
  assign mode_eff = (accept && kcnt_q == '0) ? signed_i : mode_q;
  assign row_nxt  = row_q + RW'(1);

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_a_skew
    logic [DATA_WIDTH-1:0] a_feed;
    assign a_feed = flushing ? '0 : a_i[gi];
    if (gi == 0) begin : g_pass
      assign h_w[gi][0] = a_feed;
    end else begin : g_dly
      logic [DATA_WIDTH-1:0] line_q [gi];
      always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) line_q <= '{default: '0};
        else if (clr) line_q <= '{default: '0};
        else if (en) begin
          line_q[0] <= a_feed;
          for (int k = 1; k < gi; k++) line_q[k] <= line_q[k-1];
        end
      end
      assign h_w[gi][0] = line_q[gi-1];
    end
  end

  for (genvar gj = 0; gj < COLS; gj++) begin : g_b_skew
    logic [DATA_WIDTH-1:0] b_feed;
    assign b_feed = flushing ? '0 : b_i[gj];
    if (gj == 0) begin : g_pass
      assign v_w[0][gj] = b_feed;
    end else begin : g_dly
      logic [DATA_WIDTH-1:0] line_q [gj];
      always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) line_q <= '{default: '0};
        else if (clr) line_q <= '{default: '0};
        else if (en) begin
          line_q[0] <= b_feed;
          for (int k = 1; k < gj; k++) line_q[k] <= line_q[k-1];
        end
      end
      assign v_w[0][gj] = line_q[gj-1];
    end
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_col
      ss_mac_pe #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_pe (
        .clk      (clk),
        .reset_ni (reset_ni),
        .en_i     (en),
        .clr_i    (clr),
        .signed_i (mode_eff),
        .west_i   (h_w[gi][gj]),
        .north_i  (v_w[gi][gj]),
        .east_o   (h_w[gi][gj+1]),
        .south_o  (v_w[gi+1][gj]),
        .acc_o    (acc_w[gi][gj])
      );
    end
  end

  // Operands leaving the far edge of the array are dropped.
  always_comb begin
    unused_edge = 1'b0;
    for (int i = 0; i < ROWS; i++) unused_edge = unused_edge ^ (^h_w[i][COLS]);
    for (int j = 0; j < COLS; j++) unused_edge = unused_edge ^ (^v_w[ROWS][j]);
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= FEED;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      kover_q     <= 1'b0;
      mode_q      <= 1'b0;
      row_q       <= '0;
      kcnt_q      <= '0;
      fcnt_q      <= '0;
      c_q         <= '0;
    end else begin
      case (state_q)
        FEED: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            if (kcnt_q == '0) begin
              mode_q  <= signed_i;
              kover_q <= 1'b0;
            end
            if (in_last_i || kcnt_q == KW'(MAX_K - 1)) begin
              kcnt_q     <= '0;
              in_ready_q <= 1'b0;
              if (!in_last_i) kover_q <= 1'b1;
              if (ROWS + COLS == 2) state_q <= DRAIN;
              else begin
                state_q <= FLUSH;
                fcnt_q  <= FLUSH_INIT;
              end
            end else begin
              kcnt_q <= kcnt_q + KW'(1);
            end
          end
        end
        FLUSH: begin
          if (fcnt_q == '0) state_q <= DRAIN;
          else fcnt_q <= fcnt_q - FW'(1);
        end
        DRAIN: begin
          // First DRAIN cycle registers row 0; later rows load on each handshake.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            for (int j = 0; j < COLS; j++) c_q[j] <= acc_w[row_q][j];
          end else if (out_ready_i) begin
            if (row_q == RW'(ROWS - 1)) begin
              out_valid_q <= 1'b0;
              row_q       <= '0;
              c_q         <= '0;
              in_ready_q  <= 1'b1;
              state_q     <= FEED;
            end else begin
              row_q <= row_nxt;
              for (int j = 0; j < COLS; j++) c_q[j] <= acc_w[row_nxt][j];
            end
          end
        end
        default: state_q <= FEED;
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_row_o   = row_q;
  assign c_o         = c_q;
  assign kover_o     = kover_q;

endmodule

// File: tb/tb_sum_stationary_stream.sv
// Directed and randomized tiles checked against a plain matrix-product reference.
module tb_sum_stationary_stream;
  localparam int DW = 8, R = 4, C = 4, MK = 16, AW = 20;

  logic clk = 1'b0, reset_ni = 1'b0, signed_i = 1'b0;
  logic in_valid_i = 1'b0, in_last_i = 1'b0, out_ready_i = 1'b0;
  logic in_ready_o, out_valid_o, kover_o;
  logic [1:0] out_row_o;
  logic [R-1:0][DW-1:0] a_i = '0;
  logic [C-1:0][DW-1:0] b_i = '0;
  logic [C-1:0][AW-1:0] c_o;

  int n_vec = 0, n_err = 0;
  int a_m [MK][R];
  int b_m [MK][C];

  always #5 clk = ~clk;

  sum_stationary_stream dut (
    .clk(clk), .reset_ni(reset_ni), .signed_i(signed_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_last_i(in_last_i),
    .a_i(a_i), .b_i(b_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_row_o(out_row_o), .c_o(c_o), .kover_o(kover_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] model(input int i, input int j, input int K, input bit sgn);
    longint s = 0;
    for (int k = 0; k < K; k++) begin
      longint av = a_m[k][i];
      longint bv = b_m[k][j];
      if (sgn && av > 127) av -= 256;
      if (sgn && bv > 127) bv -= 256;
      s += av * bv;
    end
    return AW'(s);
  endfunction

  task automatic set_test1();
    for (int k = 0; k < MK; k++) begin
      for (int i = 0; i < R; i++) a_m[k][i] = (i == k) ? 1 : 0;
      for (int j = 0; j < C; j++) b_m[k][j] = k * 4 + j + 1;
    end
  endtask

  task automatic set_const(input int av, input int bv);
    for (int k = 0; k < MK; k++) begin
      for (int i = 0; i < R; i++) a_m[k][i] = av;
      for (int j = 0; j < C; j++) b_m[k][j] = bv;
    end
  endtask

  task automatic set_rand();
    for (int k = 0; k < MK; k++) begin
      for (int i = 0; i < R; i++) a_m[k][i] = int'($urandom_range(255));
      for (int j = 0; j < C; j++) b_m[k][j] = int'($urandom_range(255));
    end
  endtask

  // Ends on the negedge right after the edge that accepted the last beat.
  task automatic feed(input int K, input bit sgn, input bit gaps, input bit setlast);
    int k = 0;
    int guard = 0;
    bit skip = 1'b0;
    while (k < K && guard < 500) begin
      @(negedge clk);
      guard++;
      if (gaps && skip) begin
        in_valid_i = 1'b0;
        in_last_i  = 1'b1;
        a_i = $urandom;
        b_i = $urandom;
        skip = 1'b0;
      end else begin
        in_valid_i = 1'b1;
        in_last_i  = setlast && (k == K - 1);
        signed_i   = (k == 0) ? sgn : ~sgn;
        for (int i = 0; i < R; i++) a_i[i] = DW'(a_m[k][i]);
        for (int j = 0; j < C; j++) b_i[j] = DW'(b_m[k][j]);
        if (in_ready_o) begin
          k++;
          skip = gaps;
        end
      end
    end
    @(negedge clk);
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    check("feed_beats", k, K);
  endtask

  task automatic wait_lat(input string tag);
    int n = 0;
    while (!out_valid_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, 7);
  endtask

  task automatic check_row(input int r, input int K, input bit sgn, input string tag);
    check($sformatf("%s_valid_r%0d", tag, r), out_valid_o, 1);
    check($sformatf("%s_row_r%0d", tag, r), out_row_o, r);
    check($sformatf("%s_inready_r%0d", tag, r), in_ready_o, 0);
    for (int j = 0; j < C; j++)
      check($sformatf("%s_c_r%0d_c%0d", tag, r, j), c_o[j], model(r, j, K, sgn));
  endtask

  task automatic drain(input int K, input bit sgn, input int stall_row, input string tag);
    for (int r = 0; r < R; r++) begin
      if (r == stall_row) begin
        out_ready_i = 1'b0;
        repeat (5) begin
          check_row(r, K, sgn, {tag, "_stall"});
          @(negedge clk);
        end
      end
      check_row(r, K, sgn, tag);
      out_ready_i = 1'b1;
      @(negedge clk);
    end
    out_ready_i = 1'b0;
    check({tag, "_done_valid"}, out_valid_o, 0);
    check({tag, "_done_inready"}, in_ready_o, 1);
  endtask

  task automatic tile(input int K, input bit sgn, input bit gaps, input int stall_row, input string tag);
    feed(K, sgn, gaps, 1'b1);
    check({tag, "_kover"}, kover_o, 0);
    wait_lat(tag);
    drain(K, sgn, stall_row, tag);
  endtask

  initial begin
    @(negedge clk);
    check("rst_inready", in_ready_o, 0);
    check("rst_valid", out_valid_o, 0);
    check("rst_row", out_row_o, 0);
    check("rst_c", c_o, 0);
    check("rst_kover", kover_o, 0);
    @(negedge clk);
    reset_ni = 1'b1;
    check("rel_inready_pre", in_ready_o, 0);
    @(negedge clk);
    check("rel_inready_post", in_ready_o, 1);

    set_test1();
    tile(4, 1'b0, 1'b0, -1, "t1");

    set_const(8'hFF, 8'h02);
    feed(1, 1'b1, 1'b0, 1'b1);
    wait_lat("t2s");
    check("t2s_const", c_o[0], 20'hFFFFE);
    drain(1, 1'b1, -1, "t2s");
    tile(1, 1'b0, 1'b0, -1, "t2u");

    set_test1();
    tile(4, 1'b0, 1'b0, 1, "t3");
    tile(4, 1'b0, 1'b1, -1, "t4");

    set_const(1, 1);
    feed(16, 1'b0, 1'b0, 1'b0);
    check("t5_kover_set", kover_o, 1);
    wait_lat("t5");
    check("t5_const", c_o[3], 16);
    drain(16, 1'b0, -1, "t5");
    set_test1();
    tile(4, 1'b0, 1'b0, -1, "t5_next");

    set_const(1, 1);
    feed(16, 1'b0, 1'b0, 1'b0);
    check("t6_kover_pre", kover_o, 1);
    repeat (2) @(negedge clk);
    reset_ni = 1'b0;
    #1;
    check("t6_kover", kover_o, 0);
    check("t6_inready", in_ready_o, 0);
    check("t6_valid", out_valid_o, 0);
    check("t6_row", out_row_o, 0);
    check("t6_c", c_o, 0);
    @(negedge clk);
    reset_ni = 1'b1;
    set_test1();
    tile(4, 1'b0, 1'b0, -1, "t6_after");

    for (int t = 0; t < 6; t++) begin
      int stall;
      set_rand();
      stall = int'($urandom_range(4)) - 1;
      tile(int'($urandom_range(16, 1)), 1'(($urandom >> 3) & 1), 1'(($urandom >> 5) & 1),
           stall, $sformatf("rnd%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
